serial_mag_cmp_ctrl: RTL
========================

// Module: serial_mag_cmp_ctrl
// PURPOSE
//   Sequencer that shares one SLICE-bit cascadable magnitude-comparator slice across
//   a WIDTH-bit compare. It walks the operands slice by slice, MSB slice first, and
//   feeds each slice's result into the next slice's cascade input. It stops early
//   once the operands differ. Sits between operand producers and consumers of
//   lt/eq/gt flags. Uses valid/ready handshakes on both sides.
// PARAMETERS
//   WIDTH   32  operand width in bits; WIDTH % SLICE == 0 is required (elaboration error otherwise)
//   SLICE   4   bits compared per cycle by the shared slice
//   NSLICE  WIDTH/SLICE (localparam); IDXW = max(1,$clog2(NSLICE)) slice-index width
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous reset, active low
//   in_valid     in   1      operand pair offered
//   in_ready     out  1      block can accept a pair (high only in IDLE)
//   op_a         in   WIDTH  operand A
//   op_b         in   WIDTH  operand B
//   signed_mode  in   1      1: two's-complement compare; 0: unsigned; sampled with operands
//   out_valid    out  1      result available
//   out_ready    in   1      consumer takes result
//   lt/eq/gt     out  1 each A<B / A==B / A>B; exactly one high while out_valid, all 0 otherwise
//   busy         out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (rst_n low at a clk edge): state=IDLE, out_valid=0, lt=eq=gt=0, busy=0,
//     idx=0, cascade=EQ. in_ready=1 from the first cycle after reset. Reset mid-RUN or
//     mid-DONE discards the operation; no result is ever emitted for it.
//   Cascade encoding (2 bits): EQ=2'b00, LT=2'b01, GT=2'b10; 2'b11 is illegal and
//     never produced.
//   IDLE: in_ready=1. On in_valid&in_ready: register op_a/op_b. If signed_mode=1,
//     invert bit WIDTH-1 of both registered operands, which maps signed order onto
//     unsigned order. Set idx=NSLICE-1 and cascade=EQ, then go to RUN.
//   RUN: each cycle, the slice compares a_q[idx*SLICE+:SLICE] with b_q[idx*SLICE+:SLICE]
//     using the cascade input; cascade<=slice result.
//     - result!=EQ, or idx==0 -> go to DONE; lt/eq/gt are registered from the result.
//     - otherwise idx<=idx-1 and stay in RUN.
//     Slice rule: if cascade_in!=EQ, pass cascade_in through; else the slice's own
//     unsigned compare decides.
//   DONE: out_valid=1; lt/eq/gt are held stable until the handshake. On out_ready, the
//     next state is IDLE and out_valid/lt/eq/gt clear at that edge. in_ready=0 in DONE:
//     no overlap, so a new pair is accepted no earlier than the cycle after the handoff.
//   Latency: k RUN cycles. k = 1 + number of leading equal slices, capped at NSLICE.
//     out_valid rises k edges after the accept edge. Throughput is one result per
//     k+2 cycles at best.
//   Input changes after acceptance have no effect; operands are registered.
//   out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored
//     (no handshake occurs).
//   NSLICE==1: RUN always lasts exactly one cycle.
// STRUCTURE
//   Package cmp_ctrl_pkg holds:
//     - state enum {IDLE,RUN,DONE}
//     - cascade localparams CASC_EQ/CASC_LT/CASC_GT
//     - function helpers for slice extraction
//   Sub-module cmp_slice_cascade #(SLICE): purely combinational slice.
//     Inputs: a, b, casc_in[1:0]. Output: casc_out[1:0].
//     Exactly one instance. The controller owns FSM, index counter, operand and result
//     registers.
// TESTING  (WIDTH=32, SLICE=4)
//   1. unsigned a=0x12345678 b=0x12345678 -> 8 RUN cycles, eq=1 lt=0 gt=0, out_valid
//      8 edges after accept.
//   2. unsigned a=0x90000000 b=0x10000000 -> gt=1 after 1 RUN cycle.
//      Same pair with signed_mode=1 -> lt=1 after 1 cycle.
//   3. unsigned a=0x00000001 b=0x00000002 -> lt=1 after 8 cycles.
//      signed a=0xFFFFFFFF b=0x00000000 -> lt=1 after 1 cycle.
//   4. Backpressure: result gt pending, hold out_ready=0 for 5 cycles, toggle in_valid
//      -> out_valid/gt stable, in_ready=0, no accept. out_ready=1 -> IDLE next cycle,
//      in_ready=1.
//   5. Reset: rst_n=0 on the 3rd RUN cycle of case 1 -> next cycle out_valid=0,
//      lt=eq=gt=0, busy=0, in_ready=1; no stale result appears afterwards.
//   6. Back-to-back: in_valid held high with 3 different pairs, out_ready=1 -> three
//      correct results in order. Each accept occurs exactly one cycle after the
//      previous result's handoff.

Source files
------------

// File: rtl/cmp_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator controller.
//   state_t          controller state encoding
//   CASC_EQ/LT/GT    2-bit cascade encoding carried between slices (2'b11 unused)
//   slice_lsb()      bit offset of a slice inside a full-width operand
package cmp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CASC_EQ = 2'b00;
    localparam logic [1:0] CASC_LT = 2'b01;
    localparam logic [1:0] CASC_GT = 2'b10;

    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned slice_w);
        return idx * slice_w;
    endfunction

endpackage

// File: rtl/serial_mag_cmp_ctrl_if.sv
// Handshake bundle between operand producer / result consumer and the
// serial magnitude comparator.
//   in_valid, in_ready      operand-side handshake
//   op_a, op_b, signed_mode operand pair and compare mode
//   out_valid, out_ready    result-side handshake
//   lt, eq, gt              one-hot result flags while out_valid
//   busy                    comparator is working on or holding a result
// master: producer/consumer side. slave: comparator side.
interface serial_mag_cmp_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, signed_mode, out_ready,
        input  in_ready, out_valid, lt, eq, gt, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, signed_mode, out_ready,
        output in_ready, out_valid, lt, eq, gt, busy
    );
endinterface

// File: rtl/cmp_slice_cascade.sv
// Combinational SLICE-bit cascadable magnitude comparator slice.
//   i_a, i_b      slice operands (unsigned)
//   i_casc_in     result of the more significant slices
//   o_casc_out    i_casc_in when already decided, otherwise this slice's compare
module cmp_slice_cascade
    import cmp_ctrl_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic [1:0]       i_casc_in,
    output logic [1:0]       o_casc_out
);

    always_comb begin
        o_casc_out = CASC_EQ;
        if (i_casc_in != CASC_EQ) begin
            o_casc_out = i_casc_in;
        end else if (i_a < i_b) begin
            o_casc_out = CASC_LT;
        end else if (i_a > i_b) begin
            o_casc_out = CASC_GT;
        end
    end

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Serial magnitude comparator: walks a WIDTH-bit operand pair one SLICE-bit
// slice per cycle, MSB slice first, through a single shared cascade slice and
// stops as soon as the operands are known to differ.
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    handshake bundle (slave side), see serial_mag_cmp_ctrl_if
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for an operand pair, in_ready=1
//   RUN   | comparing slice r_idx, one slice per cycle
//   DONE  | result presented with out_valid=1 until out_ready
module serial_mag_cmp_ctrl
    import cmp_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_mag_cmp_ctrl_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("serial_mag_cmp_ctrl: WIDTH must be a multiple of SLICE");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDXW-1:0]  r_idx;
    logic [1:0]       r_casc;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [1:0]       w_casc_out;
    logic             w_run_end;

    // Shift rather than indexed part-select keeps the variable slice select
    // free of index-width concerns.
    assign w_a_slice = SLICE'(r_a >> slice_lsb(32'(r_idx), SLICE));
    assign w_b_slice = SLICE'(r_b >> slice_lsb(32'(r_idx), SLICE));

    cmp_slice_cascade #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a        (w_a_slice),
        .i_b        (w_b_slice),
        .i_casc_in  (r_casc),
        .o_casc_out (w_casc_out)
    );

    assign w_run_end = (w_casc_out != CASC_EQ) || (r_idx == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next_state = RUN;
            RUN:     if (w_run_end)     w_next_state = DONE;
            DONE:    if (bus.out_ready) w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        bus.busy      = (r_state != IDLE);
        bus.lt        = r_lt;
        bus.eq        = r_eq;
        bus.gt        = r_gt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= '0;
            r_casc <= CASC_EQ;
            r_lt   <= 1'b0;
            r_eq   <= 1'b0;
            r_gt   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Flipping the sign bit of both operands maps
                        // two's-complement order onto unsigned order.
                        r_a    <= bus.signed_mode ? (bus.op_a ^ MSB_MASK) : bus.op_a;
                        r_b    <= bus.signed_mode ? (bus.op_b ^ MSB_MASK) : bus.op_b;
                        r_idx  <= IDX_TOP;
                        r_casc <= CASC_EQ;
                    end
                end
                RUN: begin
                    r_casc <= w_casc_out;
                    if (w_run_end) begin
                        r_lt <= (w_casc_out == CASC_LT);
                        r_eq <= (w_casc_out == CASC_EQ);
                        r_gt <= (w_casc_out == CASC_GT);
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_lt <= 1'b0;
                        r_eq <= 1'b0;
                        r_gt <= 1'b0;
                    end
                end
                default: begin
                    r_lt <= 1'b0;
                    r_eq <= 1'b0;
                    r_gt <= 1'b0;
                end
            endcase
        end
    end

endmodule
